mux2x1_tx_serializer: RTL and testbench

- TX-side counterpart of the RX 1x2 lane demux: merges two byte lanes into one serial byte stream, alternating lane 0 and lane 1.
- Each lane has a small FIFO to absorb burstiness. The output is a registered valid/ready stage feeding the downstream link.
- Strict alternation keeps byte order aligned with the receiver's alternating demux.

---
 rtl/mux2x1_tx_serializer.sv | 159 +++++++++++++++
 tb/tb_mux2x1_tx_serializer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux2x1_tx_serializer.sv
// rtl/mux2x1_tx_serializer.sv - two-lane byte serializer with per-lane FIFOs and registered output (optional MUX_SKIP_EMPTY_EN)
module mux2x1_tx_serializer #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] in0_data,
    input  logic              in0_valid,
    output logic              in0_ready,
    input  logic [DATA_W-1:0] in1_data,
    input  logic              in1_valid,
    output logic              in1_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_lane,
    output logic [CNT_W-1:0]  fifo0_cnt,
    output logic [CNT_W-1:0]  fifo1_cnt
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(FIFO_DEPTH);

    typedef enum logic {
        SERVE0 = 1'b0,
        SERVE1 = 1'b1
    } state_t;

    state_t state;
    state_t next_state;

    logic [DATA_W-1:0] mem0 [FIFO_DEPTH];
    logic [DATA_W-1:0] mem1 [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr0;
    logic [PTR_W-1:0]  rd_ptr0;
    logic [PTR_W-1:0]  wr_ptr1;
    logic [PTR_W-1:0]  rd_ptr1;

    logic wr0;
    logic wr1;
    logic pop0;
    logic pop1;
    logic nonempty0;
    logic nonempty1;
    logic load;
    logic serve_lane;
    logic out_free;

    // Ready is derived from the registered count, so a full lane refuses a
    // write even when it is being popped in the same cycle.
    assign in0_ready = !reset && (fifo0_cnt != FULL_CNT);
    assign in1_ready = !reset && (fifo1_cnt != FULL_CNT);
    assign wr0       = in0_valid && in0_ready;
    assign wr1       = in1_valid && in1_ready;
    assign nonempty0 = (fifo0_cnt != '0);
    assign nonempty1 = (fifo1_cnt != '0);
    assign out_free  = !out_valid || out_ready;
    assign pop0      = load && !serve_lane;
    assign pop1      = load && serve_lane;

    // Selector state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= SERVE0;
        end else begin
            state <= next_state;
        end
    end

    // Pick the lane to serve, decide whether the output stage loads, and
    // advance the selector to the lane opposite the one actually served.
    always_comb begin
        next_state = state;
        serve_lane = (state == SERVE1);
        load       = 1'b0;
`ifdef MUX_SKIP_EMPTY_EN
        if (state == SERVE0 && !nonempty0 && nonempty1) begin
            serve_lane = 1'b1;
        end else if (state == SERVE1 && !nonempty1 && nonempty0) begin
            serve_lane = 1'b0;
        end
`endif
        if (out_free && (serve_lane ? nonempty1 : nonempty0)) begin
            load       = 1'b1;
            next_state = serve_lane ? SERVE0 : SERVE1;
        end
    end

    // Lane FIFO storage; contents need no reset because pointers and counts do.
    always_ff @(posedge clk) begin
        if (wr0) begin
            mem0[wr_ptr0] <= in0_data;
        end
        if (wr1) begin
            mem1[wr_ptr1] <= in1_data;
        end
    end

    // Lane 0 pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr0   <= '0;
            rd_ptr0   <= '0;
            fifo0_cnt <= '0;
        end else begin
            if (wr0) begin
                wr_ptr0 <= wr_ptr0 + 1'b1;
            end
            if (pop0) begin
                rd_ptr0 <= rd_ptr0 + 1'b1;
            end
            case ({wr0, pop0})
                2'b10:   fifo0_cnt <= fifo0_cnt + 1'b1;
                2'b01:   fifo0_cnt <= fifo0_cnt - 1'b1;
                default: fifo0_cnt <= fifo0_cnt;
            endcase
        end
    end

    // Lane 1 pointers and occupancy.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr1   <= '0;
            rd_ptr1   <= '0;
            fifo1_cnt <= '0;
        end else begin
            if (wr1) begin
                wr_ptr1 <= wr_ptr1 + 1'b1;
            end
            if (pop1) begin
                rd_ptr1 <= rd_ptr1 + 1'b1;
            end
            case ({wr1, pop1})
                2'b10:   fifo1_cnt <= fifo1_cnt + 1'b1;
                2'b01:   fifo1_cnt <= fifo1_cnt - 1'b1;
                default: fifo1_cnt <= fifo1_cnt;
            endcase
        end
    end

    // Registered output stage: load a new byte when free, drop valid on drain,
    // otherwise hold data and lane stable.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_data  <= '0;
            out_valid <= 1'b0;
            out_lane  <= 1'b0;
        end else if (load) begin
            out_data  <= serve_lane ? mem1[rd_ptr1] : mem0[rd_ptr0];
            out_lane  <= serve_lane;
            out_valid <= 1'b1;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2x1_tx_serializer.sv
// tb/tb_mux2x1_tx_serializer.sv - directed self-checking bench for mux2x1_tx_serializer
module tb_mux2x1_tx_serializer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] in0_data = '0;
    logic       in0_valid = 1'b0;
    logic       in0_ready;
    logic [7:0] in1_data = '0;
    logic       in1_valid = 1'b0;
    logic       in1_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic       out_lane;
    logic [2:0] fifo0_cnt;
    logic [2:0] fifo1_cnt;

    int errors = 0;
    int checks = 0;

    mux2x1_tx_serializer #(
        .DATA_W(8),
        .FIFO_DEPTH(4),
        .CNT_W(3)
    ) dut (
        .clk(clk),
        .reset(reset),
        .in0_data(in0_data),
        .in0_valid(in0_valid),
        .in0_ready(in0_ready),
        .in1_data(in1_data),
        .in1_valid(in1_valid),
        .in1_ready(in1_ready),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_lane(out_lane),
        .fifo0_cnt(fifo0_cnt),
        .fifo1_cnt(fifo1_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic lane);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(d));
        check({tag, "_lane"}, 32'(out_lane), 32'(lane));
    endtask

    task automatic do_reset();
        reset = 1'b1;
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    initial begin
        logic [7:0] exp_q [20];
        int i0;
        int i1;
        int k;
        logic w0;
        logic w1;

        // Reset state
        tick();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", 32'(out_data), 32'd0);
        check("rst_lane", 32'(out_lane), 32'd0);
        check("rst_cnt0", 32'(fifo0_cnt), 32'd0);
        check("rst_cnt1", 32'(fifo1_cnt), 32'd0);
        check("rst_rdy0", 32'(in0_ready), 32'd0);
        check("rst_rdy1", 32'(in1_ready), 32'd0);
        do_reset();
        check("post_rst_rdy0", 32'(in0_ready), 32'd1);

        // Basic alternation A0,B0,A1,B1
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hA0;
        in1_valid = 1'b1; in1_data = 8'hB0;
        tick();
        check("t1_lat_valid", 32'(out_valid), 32'd0);
        check("t1_cnt0", 32'(fifo0_cnt), 32'd1);
        in0_data = 8'hA1;
        in1_data = 8'hB1;
        tick();
        check_out("t1_a0", 8'hA0, 1'b0);
        check("t1_cnt0b", 32'(fifo0_cnt), 32'd1);
        check("t1_cnt1b", 32'(fifo1_cnt), 32'd2);
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        check_out("t1_b0", 8'hB0, 1'b1);
        tick();
        check_out("t1_a1", 8'hA1, 1'b0);
        tick();
        check_out("t1_b1", 8'hB1, 1'b1);
        tick();
        check("t1_drain_valid", 32'(out_valid), 32'd0);
        check("t1_drain_hold", 32'(out_data), 32'hB1);

        // Only lane 1 has data
        in1_valid = 1'b1; in1_data = 8'h55;
        tick();
        in1_valid = 1'b0;
`ifdef MUX_SKIP_EMPTY_EN
        tick();
        check_out("t2_skip55", 8'h55, 1'b1);
        in0_valid = 1'b1; in0_data = 8'h56;
        in1_valid = 1'b1; in1_data = 8'h57;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        tick();
        check_out("t2_next0", 8'h56, 1'b0);
        tick();
        check_out("t2_next1", 8'h57, 1'b1);
`else
        for (int c = 0; c < 6; c++) begin
            tick();
            check("t2_strict_valid", 32'(out_valid), 32'd0);
        end
        check("t2_strict_cnt1", 32'(fifo1_cnt), 32'd1);
`endif
        do_reset();

        // Backpressure: fill both lanes with out_ready=0
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            in0_valid = 1'b1; in0_data = 8'h30 + 8'(i);
            in1_valid = 1'b1; in1_data = 8'h40 + 8'(i);
            tick();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check("t3_cnt0", 32'(fifo0_cnt), 32'd3);
        check("t3_cnt1", 32'(fifo1_cnt), 32'd4);
        check("t3_rdy0", 32'(in0_ready), 32'd1);
        check("t3_rdy1", 32'(in1_ready), 32'd0);
        tick();
        tick();
        check_out("t3_stall", 8'h30, 1'b0);
        // Full lane 1 is popped while a write is offered: write must be refused
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'hEE;
        tick();
        in1_valid = 1'b0;
        check_out("t3_b0", 8'h40, 1'b1);
        check("t3_full_refuse_cnt1", 32'(fifo1_cnt), 32'd3);
        check("t3_cnt0_after", 32'(fifo0_cnt), 32'd3);
        for (int i = 1; i < 4; i++) begin
            tick();
            check_out("t3_drain_a", 8'h30 + 8'(i), 1'b0);
            tick();
            check_out("t3_drain_b", 8'h40 + 8'(i), 1'b1);
        end
        tick();
        check("t3_end_valid", 32'(out_valid), 32'd0);

        // Simultaneous write and pop on a lane holding 2 bytes
        out_ready = 1'b0;
        in0_valid = 1'b1; in0_data = 8'h61;
        in1_valid = 1'b1; in1_data = 8'h71;
        tick();
        in0_data = 8'h62;
        in1_data = 8'h72;
        tick();
        in0_data = 8'h63;
        in1_valid = 1'b0;
        tick();
        in0_valid = 1'b0;
        check("t4_cnt1_pre", 32'(fifo1_cnt), 32'd2);
        check_out("t4_hold", 8'h61, 1'b0);
        out_ready = 1'b1;
        in1_valid = 1'b1; in1_data = 8'h73;
        tick();
        in1_valid = 1'b0;
        check_out("t4_71", 8'h71, 1'b1);
        check("t4_cnt1_same", 32'(fifo1_cnt), 32'd2);
        check("t4_cnt0", 32'(fifo0_cnt), 32'd2);
        tick();
        check_out("t4_62", 8'h62, 1'b0);
        tick();
        check_out("t4_72", 8'h72, 1'b1);
        tick();
        check_out("t4_63", 8'h63, 1'b0);
        tick();
        check_out("t4_73", 8'h73, 1'b1);
        tick();
        check("t4_end_valid", 32'(out_valid), 32'd0);

        // Streaming 10 bytes per lane with pointer wrap
        for (int i = 0; i < 10; i++) begin
            exp_q[2*i]   = 8'hA0 + 8'(i);
            exp_q[2*i+1] = 8'hB0 + 8'(i);
        end
        i0 = 0;
        i1 = 0;
        k = 0;
        for (int c = 0; c < 200 && k < 20; c++) begin
            in0_valid = (i0 < 10);
            in0_data  = 8'hA0 + 8'(i0);
            in1_valid = (i1 < 10);
            in1_data  = 8'hB0 + 8'(i1);
            w0 = in0_valid && in0_ready;
            w1 = in1_valid && in1_ready;
            tick();
            if (w0) i0++;
            if (w1) i1++;
            if (out_valid) begin
                check("t5_data", 32'(out_data), 32'(exp_q[k]));
                check("t5_lane", 32'(out_lane), 32'(k % 2));
                k++;
            end
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check("t5_done", 32'(k), 32'd20);
        tick();
        check("t5_end_valid", 32'(out_valid), 32'd0);
        check("t5_end_cnt0", 32'(fifo0_cnt), 32'd0);

        // Reset mid-burst
        out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            in0_valid = 1'b1; in0_data = 8'h90 + 8'(i);
            in1_valid = 1'b1; in1_data = 8'h98 + 8'(i);
            tick();
        end
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check("t6_pre_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        check("t6_rst_valid", 32'(out_valid), 32'd0);
        check("t6_rst_cnt0", 32'(fifo0_cnt), 32'd0);
        check("t6_rst_cnt1", 32'(fifo1_cnt), 32'd0);
        check("t6_rst_rdy0", 32'(in0_ready), 32'd0);
        reset = 1'b0;
        out_ready = 1'b1;
        in0_valid = 1'b1; in0_data = 8'hC0;
        in1_valid = 1'b1; in1_data = 8'hD0;
        tick();
        in0_valid = 1'b0;
        in1_valid = 1'b0;
        check("t6_nostale", 32'(out_valid), 32'd0);
        tick();
        check_out("t6_c0", 8'hC0, 1'b0);
        tick();
        check_out("t6_d0", 8'hD0, 1'b1);
        tick();
        check("t6_end_valid", 32'(out_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
